// File: rtl/uart_rx_char.sv
// uart_rx_char: UART receive front end, one ASCII byte per frame.
//
// Turns the asynchronous rxd line into framed bytes with a single-cycle
// char_valid strobe for the downstream sequence checker.  The line is
// double-flopped, the start bit is qualified at mid-bit, every following bit is
// sampled at its centre, and the stop bit is checked before a byte is released.
//
// Build option:
//   UART_RX_PARITY_EN  defined   -> 8E1 frames.  A PARITY state is present and
//                                   parity_error strobes on an even-parity mismatch.
//                      undefined -> 8N1 frames.  parity_error is tied low.
//
// Handshake: char_valid, frame_error and parity_error are mutually exclusive
// one-cycle strobes with no backpressure.  ascii_char is valid in the cycle
// char_valid is high and holds its value until the next good frame.
//
// state_o exposes the FSM state for observation:
//   0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 BREAK.
//
// CLKS_PER_BIT must be at least 4.

module uart_rx_char #(
  parameter int CLKS_PER_BIT = 666
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] ascii_char,
  output logic       char_valid,
  output logic       frame_error,
  output logic       parity_error,
  output logic       busy,
  output logic [2:0] state_o
);

  // Counter geometry.  The counter only has to reach N-1, so clog2(N) bits suffice.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  logic [1:0]    sync_q;
  logic          rx_s;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    char_q;
  logic          char_valid_q;
  logic          frame_error_q;
  logic          busy_q;
  logic          parity_ok;
  logic          bit_end;
  logic          half_end;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  assign rx_s     = sync_q[1];
  assign bit_end  = (cnt_q == BIT_LAST);
  assign half_end = (cnt_q == HALF_LAST);

`ifdef UART_RX_PARITY_EN
  logic parity_bit_q;
  logic parity_error_q;

  // Even parity: data bits and parity bit together must XOR to zero.
  assign parity_ok    = ~(^{shift_q, parity_bit_q});
  assign parity_error = parity_error_q;
`else
  assign parity_ok    = 1'b1;
  assign parity_error = 1'b0;
`endif

  // Receive FSM with registered strobes, byte register and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      idx_q          <= 3'd0;
      shift_q        <= 8'h00;
      char_q         <= 8'h00;
      char_valid_q   <= 1'b0;
      frame_error_q  <= 1'b0;
      busy_q         <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q   <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      // Strobes are high for exactly one cycle after the edge that sets them.
      char_valid_q   <= 1'b0;
      frame_error_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        // Mid start bit: a line that has gone back high was a glitch.
        S_START: begin
          if (half_end) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= S_DATA;
              idx_q   <= 3'd0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        // One full bit period after the previous centre lands on the next centre.
        S_DATA: begin
          if (bit_end) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            cnt_q        <= '0;
            parity_bit_q <= rx_s;
            state_q      <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif

        // Leaving at mid-stop leaves half a bit of margin to catch the next start.
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              if (parity_ok) begin
                char_q       <= shift_q;
                char_valid_q <= 1'b1;
              end else begin
`ifdef UART_RX_PARITY_EN
                parity_error_q <= 1'b1;
`endif
              end
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        // A line stuck low must return high before a new start can be seen.
        S_BREAK: begin
          if (rx_s) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ascii_char  = char_q;
  assign char_valid  = char_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_uart_rx_char.sv
// Directed testbench for uart_rx_char with CLKS_PER_BIT = 8.
// Frames are driven on the falling clock edge; a negedge monitor records every
// strobe with its cycle number, and each test task compares against
// hand-computed bytes and edge times.

module tb_uart_rx_char;

  localparam int N = 8;
  localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // rxd falling edge driven after edge k -> char_valid seen after edge k+LAT.
  localparam int LAT = 2 + H + (NB - 1) * N + 1;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BREAK = 3'd5;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [7:0] ascii_char;
  logic       char_valid;
  logic       frame_error;
  logic       parity_error;
  logic       busy;
  logic [2:0] state_o;

  int checks;
  int failures;
  int cyc;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_t[$];
  int         fe_cnt;
  int         fe_t;
  logic [7:0] fe_char;
  int         pe_cnt;
  int         excl_viol;
  int         width_viol;
  logic       strobe_prev;

  uart_rx_char #(.CLKS_PER_BIT(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd          (rxd),
    .ascii_char   (ascii_char),
    .char_valid   (char_valid),
    .frame_error  (frame_error),
    .parity_error (parity_error),
    .busy         (busy),
    .state_o      (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- strobe monitor ----------------
  initial begin
    fe_cnt = 0; fe_t = 0; fe_char = 8'h00; pe_cnt = 0;
    excl_viol = 0; width_viol = 0; strobe_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (char_valid) begin
        got_q.push_back(ascii_char);
        got_t.push_back(cyc);
      end
      if (frame_error) begin
        fe_cnt  = fe_cnt + 1;
        fe_t    = cyc;
        fe_char = ascii_char;
      end
      if (parity_error) pe_cnt = pe_cnt + 1;
      if ((32'(char_valid) + 32'(frame_error) + 32'(parity_error)) > 1) excl_viol = excl_viol + 1;
      if ((char_valid || frame_error || parity_error) && strobe_prev) width_viol = width_viol + 1;
      strobe_prev = char_valid || frame_error || parity_error;
    end else begin
      strobe_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    rxd = b;
    repeat (N) @(negedge clk);
  endtask

  // Caller is at a negedge; t_start is the edge after which rxd falls.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic par_flip, output int t_start);
    t_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) rxd = 1'b1;
`endif
    send_bit(stop_bit);
    rxd = 1'b1;
  endtask

  task automatic clear_log();
    got_q.delete();
    got_t.delete();
    exp_q.delete();
    fe_cnt = 0;
    pe_cnt = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    rxd   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rxd = ~rxd;
      @(negedge clk);
      checks++;
      if ({ascii_char, char_valid, frame_error, parity_error, busy} !== 12'h000) begin
        failures++;
        $display("FAIL reset_outputs[%0d]: got ascii=%0h cv=%0b fe=%0b pe=%0b busy=%0b exp all 0",
                 i, ascii_char, char_valid, frame_error, parity_error, busy);
      end
    end
    checks++;
    if (state_o !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d exp %0d", state_o, ST_IDLE);
    end
    rxd = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ascii_char !== 8'h00) begin
      failures++;
      $display("FAIL reset_release_idle: got busy=%0b ascii=%0h exp busy=0 ascii=00", busy, ascii_char);
    end
  endtask

  task automatic test_single();
    int t;
    clear_log();
    send_frame(8'h24, 1'b1, 1'b0, t);
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() !== 1) begin
      failures++;
      $display("FAIL single_count: got %0d pulses exp 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 8'h24) begin
        failures++;
        $display("FAIL single_char: got %0h exp 24", got_q[0]);
      end
      checks++;
      if (got_t[0] !== t + LAT) begin
        failures++;
        $display("FAIL single_latency: got cycle %0d exp %0d", got_t[0], t + LAT);
      end
    end
    checks++;
    if (fe_cnt !== 0 || pe_cnt !== 0) begin
      failures++;
      $display("FAIL single_no_error: got fe=%0d pe=%0d exp 0 0", fe_cnt, pe_cnt);
    end
    checks++;
    if (busy !== 1'b0 || ascii_char !== 8'h24) begin
      failures++;
      $display("FAIL single_hold: got busy=%0b ascii=%0h exp busy=0 ascii=24", busy, ascii_char);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2;
    clear_log();
    exp_q.push_back(8'h24);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h2B);
    send_frame(8'h24, 1'b1, 1'b0, t0);
    send_frame(8'h41, 1'b1, 1'b0, t1);
    send_frame(8'h2B, 1'b1, 1'b0, t2);
    repeat (2 * N) @(negedge clk);
    checks++;
    if (got_q.size() !== 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d pulses exp 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL b2b_char[%0d]: got %0h exp %0h", i, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if (got_t[0] !== t0 + LAT) begin
        failures++;
        $display("FAIL b2b_first_time: got %0d exp %0d", got_t[0], t0 + LAT);
      end
      checks++;
      if ((got_t[1] - got_t[0]) !== NB * N || (got_t[2] - got_t[1]) !== NB * N) begin
        failures++;
        $display("FAIL b2b_spacing: got %0d,%0d exp %0d", got_t[1] - got_t[0],
                 got_t[2] - got_t[1], NB * N);
      end
    end
  endtask

  task automatic test_glitch();
    int t;
    clear_log();
    t   = cyc;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    // t0 = t+3; busy must be up by t+4.
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy_set: got %0b exp 1 at cycle %0d", busy, cyc);
    end
    repeat (4) @(negedge clk);
    // Now at t0+H+1.
    checks++;
    if (busy !== 1'b0 || state_o !== ST_IDLE || cyc !== t + 3 + H + 1) begin
      failures++;
      $display("FAIL glitch_busy_clear: got busy=%0b state=%0d cyc=%0d exp busy=0 state=0 cyc=%0d",
               busy, state_o, cyc, t + 3 + H + 1);
    end
    repeat (3 * N) @(negedge clk);
    checks++;
    if (got_q.size() !== 0 || fe_cnt !== 0 || pe_cnt !== 0) begin
      failures++;
      $display("FAIL glitch_no_strobe: got cv=%0d fe=%0d pe=%0d exp 0 0 0", got_q.size(), fe_cnt, pe_cnt);
    end
  endtask

  task automatic test_frame_error();
    int t, t2;
    clear_log();
    send_frame(8'h5A, 1'b0, 1'b0, t);
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (state_o !== ST_BREAK || busy !== 1'b1) begin
      failures++;
      $display("FAIL fe_break_hold: got state=%0d busy=%0b exp state=5 busy=1", state_o, busy);
    end
    rxd = 1'b1;
    repeat (2 * N) @(negedge clk);
    checks++;
    if (fe_cnt !== 1 || fe_t !== t + LAT || fe_char !== 8'h2B) begin
      failures++;
      $display("FAIL fe_pulse: got cnt=%0d t=%0d ascii=%0h exp cnt=1 t=%0d ascii=2B",
               fe_cnt, fe_t, fe_char, t + LAT);
    end
    send_frame(8'h30, 1'b1, 1'b0, t2);
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== 8'h30 || got_t[0] !== t2 + LAT) begin
      failures++;
      $display("FAIL fe_recover: got n=%0d char=%0h t=%0d exp n=1 char=30 t=%0d",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx,
               (got_t.size() > 0) ? got_t[0] : -1, t2 + LAT);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int t;
    clear_log();
    d = 8'h7E;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    rxd = d[3];
    repeat (N / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || ascii_char !== 8'h00 || char_valid !== 1'b0 || state_o !== ST_IDLE) begin
      failures++;
      $display("FAIL midreset_async: got busy=%0b ascii=%0h cv=%0b state=%0d exp 0 00 0 0",
               busy, ascii_char, char_valid, state_o);
    end
    repeat (2) @(negedge clk);
    rxd   = 1'b1;
    rst_n = 1'b1;
    repeat (2 * N) @(negedge clk);
    checks++;
    if (got_q.size() !== 0 || fe_cnt !== 0 || pe_cnt !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_discard: got cv=%0d fe=%0d pe=%0d busy=%0b exp 0 0 0 0",
               got_q.size(), fe_cnt, pe_cnt, busy);
    end
    send_frame(8'h2D, 1'b1, 1'b0, t);
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() !== 1 || ascii_char !== 8'h2D) begin
      failures++;
      $display("FAIL midreset_recover: got n=%0d ascii=%0h exp n=1 ascii=2D", got_q.size(), ascii_char);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int t;
    clear_log();
    send_frame(8'h41, 1'b1, 1'b1, t);
    repeat (4) @(negedge clk);
    checks++;
    if (pe_cnt !== 1 || got_q.size() !== 0 || ascii_char !== 8'h2D) begin
      failures++;
      $display("FAIL parity_bad: got pe=%0d cv=%0d ascii=%0h exp pe=1 cv=0 ascii=2D",
               pe_cnt, got_q.size(), ascii_char);
    end
  endtask
`endif

  task automatic test_strobe_shape();
    checks++;
    if (excl_viol !== 0 || width_viol !== 0) begin
      failures++;
      $display("FAIL strobe_shape: got overlap=%0d wide=%0d exp 0 0", excl_viol, width_viol);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    rxd      = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_strobe_shape();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
